// File: rtl/q2a03_pkg.sv
// Shared types and constants for the 2A03 bus-side blocks (OAM DMA, CPU core, APU).
package q2a03_pkg;

  typedef logic [7:0]  reg8_type;
  typedef logic [15:0] reg16_type;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } dma_state_t;

  localparam reg16_type   TRIGGER_ADDR_DEF = 16'h4014;
  localparam reg16_type   OAM_ADDR_DEF     = 16'h2004;
  localparam int unsigned CLK_DIV_DEF      = 12;
  localparam int unsigned PHY2_START_DEF   = 6;

endpackage

// File: rtl/q2a03_phase_div.sv
// Master-clock divider: tick counter giving the CPU-cycle wrap strobe, phase-2 and cycle parity.
module q2a03_phase_div
  import q2a03_pkg::*;
#(
  parameter int unsigned CLK_DIV    = CLK_DIV_DEF,
  parameter int unsigned PHY2_START = PHY2_START_DEF
) (
  input  logic G_clock,
  input  logic G_reset,
  input  logic G_ready,
  output logic wrap,
  output logic phy2,
  output logic odd
);

  localparam int unsigned TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [TW-1:0] tick_q;
  logic          odd_q;

  assign wrap = G_ready && (tick_q == TW'(CLK_DIV - 1));
  assign phy2 = (tick_q >= TW'(PHY2_START));
  assign odd  = odd_q;

  always_ff @(posedge G_clock) begin
    if (!G_reset) begin
      tick_q <= '0;
      odd_q  <= 1'b0;
    end else if (wrap) begin
      tick_q <= '0;
      odd_q  <= ~odd_q;
    end else if (G_ready) begin
      tick_q <= tick_q + 1'b1;
    end
  end

endmodule

// File: rtl/q2a03_oam_dma.sv
// Sprite DMA engine: halts the CPU on a $4014 write and streams one page into OAM, else bus passthrough.
module q2a03_oam_dma
  import q2a03_pkg::*;
#(
  parameter int unsigned CLK_DIV      = CLK_DIV_DEF,
  parameter int unsigned PHY2_START   = PHY2_START_DEF,
  parameter reg16_type   TRIGGER_ADDR = TRIGGER_ADDR_DEF,
  parameter reg16_type   OAM_ADDR     = OAM_ADDR_DEF
) (
  input  logic        G_clock,
  input  logic        G_reset,
  input  logic        G_ready,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wr_data,
  input  logic        cpu_rdwr,
  output logic [7:0]  cpu_rd_data,
  output logic        cpu_ready,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wr_data,
  output logic        bus_rdwr,
  input  logic [7:0]  bus_rd_data,
  output logic        bus_phy2,
  output logic        dma_active
);

  dma_state_t state_q, state_d;
  logic       halt_q, halt_d;
  reg8_type   idx_q, idx_d;
  reg8_type   page_q, page_d;
  reg8_type   data_q, data_d;
  logic       wrap;
  logic       odd;

  q2a03_phase_div #(
    .CLK_DIV    (CLK_DIV),
    .PHY2_START (PHY2_START)
  ) u_phase_div (
    .G_clock (G_clock),
    .G_reset (G_reset),
    .G_ready (G_ready),
    .wrap    (wrap),
    .phy2    (bus_phy2),
    .odd     (odd)
  );

  always_ff @(posedge G_clock) begin
    if (!G_reset) begin
      state_q <= IDLE;
      halt_q  <= 1'b0;
      idx_q   <= '0;
      page_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      idx_q   <= idx_d;
      page_q  <= page_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    halt_d  = halt_q;
    idx_d   = idx_q;
    page_d  = page_q;
    data_d  = data_q;
    if (wrap) begin
      unique case (state_q)
        IDLE: begin
          if (!cpu_rdwr && cpu_addr == TRIGGER_ADDR) begin
            page_d  = cpu_wr_data;
            idx_d   = '0;
            halt_d  = 1'b1;
            state_d = HALT;
          end
        end
        // odd is the parity of the HALT cycle; the next cycle is odd when this one is even
        HALT:  state_d = odd ? READ : ALIGN;
        ALIGN: state_d = READ;
        READ: begin
          data_d  = bus_rd_data;
          state_d = WRITE;
        end
        WRITE: begin
          // 8-bit increment also returns idx to zero after the last byte
          idx_d   = idx_q + 8'd1;
          state_d = (idx_q == 8'hFF) ? DONE : READ;
        end
        DONE: begin
          halt_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus_addr    = cpu_addr;
    bus_wr_data = cpu_wr_data;
    bus_rdwr    = cpu_rdwr;
    unique case (state_q)
      READ: begin
        bus_addr = {page_q, idx_q};
        bus_rdwr = 1'b1;
      end
      WRITE: begin
        bus_addr    = OAM_ADDR;
        bus_rdwr    = 1'b0;
        bus_wr_data = data_q;
      end
      default: ;
    endcase
  end

  assign cpu_rd_data = bus_rd_data;
  assign cpu_ready   = G_ready & ~halt_q;
  assign dma_active  = (state_q != IDLE);

endmodule

// File: tb/tb_q2a03_oam_dma.sv
// Directed self-checking bench for q2a03_oam_dma: passthrough vector table plus DMA sequences.
module tb_q2a03_oam_dma;

  logic        G_clock = 1'b0;
  logic        G_reset = 1'b0;
  logic        G_ready = 1'b1;
  logic [15:0] cpu_addr = 16'h8000;
  logic [7:0]  cpu_wr_data = 8'h00;
  logic        cpu_rdwr = 1'b1;
  logic [7:0]  cpu_rd_data;
  logic        cpu_ready;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wr_data;
  logic        bus_rdwr;
  logic [7:0]  bus_rd_data;
  logic        bus_phy2;
  logic        dma_active;

  q2a03_oam_dma #(
    .CLK_DIV      (12),
    .PHY2_START   (6),
    .TRIGGER_ADDR (16'h4014),
    .OAM_ADDR     (16'h2004)
  ) dut (
    .G_clock     (G_clock),
    .G_reset     (G_reset),
    .G_ready     (G_ready),
    .cpu_addr    (cpu_addr),
    .cpu_wr_data (cpu_wr_data),
    .cpu_rdwr    (cpu_rdwr),
    .cpu_rd_data (cpu_rd_data),
    .cpu_ready   (cpu_ready),
    .bus_addr    (bus_addr),
    .bus_wr_data (bus_wr_data),
    .bus_rdwr    (bus_rdwr),
    .bus_rd_data (bus_rd_data),
    .bus_phy2    (bus_phy2),
    .dma_active  (dma_active)
  );

  always #5 G_clock = ~G_clock;

  int tests = 0;
  int fails = 0;

  // Memory contents: page 2 holds i^A5, other pages are offset by page^2.
  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[7:0] ^ 8'hA5 ^ a[15:8] ^ 8'h02;
  endfunction

  logic       ovr_en = 1'b0;
  logic [7:0] ovr_val = 8'h00;
  always_comb bus_rd_data = ovr_en ? ovr_val : mem_f(bus_addr);

  // Expected CPU-cycle position from the specified divider behaviour.
  logic [3:0] mtick = 4'd0;
  int         mcyc = 0;
  always @(posedge G_clock) begin
    if (!G_reset) begin
      mtick <= 4'd0;
      mcyc  <= 0;
    end else if (G_ready) begin
      if (mtick == 4'd11) begin
        mtick <= 4'd0;
        mcyc  <= mcyc + 1;
      end else begin
        mtick <= mtick + 4'd1;
      end
    end
  end

  // Bus monitor: one sample per CPU cycle at the phase-2 rise.
  logic        phy_prev = 1'b0;
  logic [7:0]  wq[$];
  logic [15:0] ra[$];
  int          stall_clks = 0;
  always @(negedge G_clock) begin
    if (G_reset && bus_phy2 && !phy_prev) begin
      if (dma_active && !bus_rdwr && bus_addr == 16'h2004) wq.push_back(bus_wr_data);
      if (dma_active && bus_rdwr && bus_addr != cpu_addr) ra.push_back(bus_addr);
    end
    if (!cpu_ready) stall_clks++;
    phy_prev = bus_phy2;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cycle_start();
    int n = 0;
    @(negedge G_clock);
    while (mtick != 4'd0 && n < 100) begin
      @(negedge G_clock);
      n++;
    end
    if (n >= 100) chk("cycle_start_timeout", 32'd1, 32'd0);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        rdwr;
    logic [7:0]  wd;
    logic [7:0]  rd;
    logic        rdy;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[7];

  // Runs one DMA; want_align selects trigger parity, pause/rst_at select mid-transfer events.
  task automatic run_dma(input logic [7:0] page, input bit want_align,
                         input bit pause, input bit rst_at);
    int n;
    int bad;
    bit paused = 0;
    bit finished = 0;
    wait_cycle_start();
    if ((mcyc % 2) != int'(want_align)) wait_cycle_start();
    wq.delete();
    ra.delete();
    stall_clks = 0;
    cpu_addr = 16'h4014; cpu_rdwr = 1'b0; cpu_wr_data = page;
    wait_cycle_start();
    cpu_addr = 16'h8000; cpu_rdwr = 1'b1; cpu_wr_data = 8'h00;
    chk("dma_started", {31'd0, dma_active}, 32'd1);
    chk("cpu_halted", {31'd0, cpu_ready}, 32'd0);
    for (n = 0; n < 8000; n++) begin
      @(negedge G_clock);
      if (pause && !paused && dma_active && bus_rdwr && bus_addr == {page, 8'h40}) begin
        paused = 1;
        G_ready = 1'b0;
        repeat (30) @(negedge G_clock);
        chk("frozen_addr", {16'd0, bus_addr}, {16'd0, page, 8'h40});
        G_ready = 1'b1;
      end
      if (rst_at && dma_active && bus_rdwr && bus_addr == {page, 8'h10}) begin
        G_reset = 1'b0;
        @(negedge G_clock);
        chk("rst_ready", {31'd0, cpu_ready}, 32'd1);
        chk("rst_active", {31'd0, dma_active}, 32'd0);
        chk("rst_bus_addr", {16'd0, bus_addr}, {16'd0, cpu_addr});
        G_reset = 1'b1;
        return;
      end
      if (!dma_active) begin
        finished = 1;
        break;
      end
    end
    chk("dma_finished", {31'd0, finished}, 32'd1);
    chk("stall_clks", stall_clks, 12 * (want_align ? 515 : 514) + (pause ? 30 : 0));
    chk("num_writes", wq.size(), 256);
    chk("num_reads", ra.size(), 256);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (i >= wq.size() || wq[i] !== mem_f({page, 8'(i)})) bad++;
      if (i >= ra.size() || ra[i] !== {page, 8'(i)}) bad++;
    end
    chk("seq_errors", bad, 0);
    chk("ready_after", {31'd0, cpu_ready}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{16'h8000, 1'b1, 8'h00, 8'h5A, 1'b1, 1'b1};
    vecs[1] = '{16'h1234, 1'b0, 8'h3C, 8'h11, 1'b1, 1'b1};
    vecs[2] = '{16'h4014, 1'b1, 8'h02, 8'h77, 1'b1, 1'b1};
    vecs[3] = '{16'h4015, 1'b0, 8'h02, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{16'hFFFC, 1'b1, 8'h00, 8'hE3, 1'b1, 1'b1};
    vecs[5] = '{16'h8000, 1'b1, 8'h00, 8'h5A, 1'b0, 1'b0};
    vecs[6] = '{16'h2004, 1'b0, 8'hC3, 8'h99, 1'b1, 1'b1};

    repeat (3) @(negedge G_clock);
    chk("reset_ready", {31'd0, cpu_ready}, 32'd1);
    chk("reset_active", {31'd0, dma_active}, 32'd0);
    chk("reset_bus_addr", {16'd0, bus_addr}, 32'h8000);
    chk("reset_phy2", {31'd0, bus_phy2}, 32'd0);
    G_reset = 1'b1;

    ovr_en = 1'b1;
    foreach (vecs[k]) begin
      wait_cycle_start();
      cpu_addr = vecs[k].addr; cpu_rdwr = vecs[k].rdwr; cpu_wr_data = vecs[k].wd;
      ovr_val = vecs[k].rd; G_ready = vecs[k].rdy;
      #2;
      chk("pt_bus_addr", {16'd0, bus_addr}, {16'd0, vecs[k].addr});
      chk("pt_bus_rdwr", {31'd0, bus_rdwr}, {31'd0, vecs[k].rdwr});
      chk("pt_bus_wd", {24'd0, bus_wr_data}, {24'd0, vecs[k].wd});
      chk("pt_cpu_rd", {24'd0, cpu_rd_data}, {24'd0, vecs[k].rd});
      chk("pt_ready", {31'd0, cpu_ready}, {31'd0, vecs[k].exp_ready});
      G_ready = 1'b1;
      wait_cycle_start();
      chk("pt_no_trigger", {31'd0, dma_active}, 32'd0);
    end
    cpu_addr = 16'h8000; cpu_rdwr = 1'b1; cpu_wr_data = 8'h00;
    ovr_en = 1'b0;

    repeat (6) @(negedge G_clock);
    chk("phy2_mid", {31'd0, bus_phy2}, {31'd0, mtick >= 4'd6});

    run_dma(8'h02, 1'b0, 1'b0, 1'b0);
    run_dma(8'h02, 1'b1, 1'b0, 1'b0);
    run_dma(8'h07, 1'b0, 1'b0, 1'b0);
    chk("page7_no_0800", {31'd0, (ra.size() > 0) && (ra[ra.size()-1] == 16'h0800)}, 32'd0);
    chk("page7_last", {16'd0, (ra.size() > 0) ? ra[ra.size()-1] : 16'h0}, 32'h07FF);
    run_dma(8'h05, 1'b1, 1'b1, 1'b0);

    run_dma(8'h03, 1'b0, 1'b0, 1'b1);
    wait_cycle_start();
    cpu_addr = 16'h4014; cpu_rdwr = 1'b1;
    wait_cycle_start();
    wait_cycle_start();
    chk("post_rst_read_4014", {31'd0, dma_active}, 32'd0);
    chk("post_rst_ready", {31'd0, cpu_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
